bitwise_logic_unit: RTL and testbench

Parametrised, pipelined successor to the fixed 4-bit AND slice of the ALU. It performs one of eight bitwise operations on `WIDTH`-bit operands and returns the result with zero, all-ones and parity flags through a two-stage valid/ready pipeline. An optional accumulate mode substitutes an internal accumulator for operand A, so bit-mask chains run without host round-trips. It sits beside the arithmetic unit in the ALU datapath, and the ALU result mux selects its output.

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_op_core.sv | 35 +++
 rtl/bitwise_logic_unit.sv | 135 +++++++++++++
 tb/tb_bitwise_logic_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types for the bitwise logic unit: operation codes and their width.
package logic_unit_pkg;

  localparam int LOGIC_OP_W = 3;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSB = 3'b111
  } logic_op_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational per-bit logic operation with zero / all-ones / parity flags.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic_op_t          op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               ones,
  output logic               parity
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_ANDN:  y = a & ~b;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

  assign zero   = ~|y;
  assign ones   = &y;
  assign parity = ^y;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Two-stage valid/ready bitwise logic pipeline with an accumulator that can
// stand in for operand A; compute and accumulator update happen on S1->S2.
module bitwise_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic               in_acc,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               out_ones,
  output logic               out_parity,
  output logic [WIDTH-1:0]   acc_q
);

  logic             s1_valid_q, s1_valid_d;
  logic_op_t        s1_op_q, s1_op_d;
  logic             s1_use_acc_q, s1_use_acc_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_ones_q, s2_ones_d;
  logic             s2_parity_q, s2_parity_d;

  logic [WIDTH-1:0] acc_d;

  logic             s2_load;
  logic             accept;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] core_y;
  logic             core_zero, core_ones, core_parity;

  // Combinational from out_ready so a full pipe can drain, advance and
  // accept in a single cycle.
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;
  assign a_eff    = s1_use_acc_q ? acc_q : s1_a_q;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op_q),
    .a      (a_eff),
    .b      (s1_b_q),
    .y      (core_y),
    .zero   (core_zero),
    .ones   (core_ones),
    .parity (core_parity)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_use_acc_d = s1_use_acc_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_zero_d    = s2_zero_q;
    s2_ones_d    = s2_ones_q;
    s2_parity_d  = s2_parity_q;
    acc_d        = acc_q;

    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_op_d      = logic_op_t'(in_op);
      s1_use_acc_d = in_acc;
      s1_a_d       = in_a;
      s1_b_d       = in_b;
    end else if (s2_load) begin
      s1_valid_d   = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_data_d   = core_y;
      s2_zero_d   = core_zero;
      s2_ones_d   = core_ones;
      s2_parity_d = core_parity;
      acc_d       = core_y;
    end else if (out_ready) begin
      s2_valid_d  = 1'b0;
    end

    // The transferring op has already used the old value; clear still wins.
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_AND;
      s1_use_acc_q <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_zero_q    <= 1'b0;
      s2_ones_q    <= 1'b0;
      s2_parity_q  <= 1'b0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_use_acc_q <= s1_use_acc_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_zero_q    <= s2_zero_d;
      s2_ones_q    <= s2_ones_d;
      s2_parity_q  <= s2_parity_d;
      acc_q        <= acc_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_zero   = s2_zero_q;
  assign out_ones   = s2_ones_q;
  assign out_parity = s2_parity_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Bench for bitwise_logic_unit: transaction-level scoreboard plus directed cases.
module tb_bitwise_logic_unit;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_acc, acc_clr, out_valid, out_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b, out_data, acc_q;
  logic         out_zero, out_ones, out_parity;

  bitwise_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_acc(in_acc), .in_a(in_a), .in_b(in_b),
    .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_ones(out_ones),
    .out_parity(out_parity), .acc_q(acc_q)
  );

  logic         w_in_valid, w_in_ready, w_out_valid, w_zero, w_ones, w_parity;
  logic [2:0]   w_op;
  logic [15:0]  w_a, w_b, w_out_data, w_acc_q;

  bitwise_logic_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_op(w_op), .in_acc(1'b0), .in_a(w_a), .in_b(w_b),
    .acc_clr(1'b0), .out_valid(w_out_valid), .out_ready(1'b1),
    .out_data(w_out_data), .out_zero(w_zero), .out_ones(w_ones),
    .out_parity(w_parity), .acc_q(w_acc_q)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: per-bit truth of each op, written as plain integer arithmetic.
  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      int x, y, v;
      x = a[i];
      y = b[i];
      case (op)
        0: v = x * y;
        1: v = (x + y > 0) ? 1 : 0;
        2: v = (x + y) % 2;
        3: v = 1 - x * y;
        4: v = (x + y == 0) ? 1 : 0;
        5: v = 1 - (x + y) % 2;
        6: v = x * (1 - y);
        default: v = y;
      endcase
      r[i] = (v != 0);
    end
    return r;
  endfunction

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_acc = '0;
  logic         stall_prev = 1'b0;
  logic [W+2:0] held = '0;

  // Samples the pins just before the coming edge, then advances one cycle.
  task automatic step();
    logic [W-1:0] e, av;
    #1;
    if (!rst) begin
      if (stall_prev && out_valid)
        chk("hold_stable", {out_data, out_zero, out_ones, out_parity}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          chk("out_zero", out_zero, e == 0);
          chk("out_ones", out_ones, e == {W{1'b1}});
          chk("out_parity", out_parity, $countones(e) % 2);
        end
      end
      if (in_valid && in_ready) begin
        av = in_acc ? model_acc : in_a;
        e = ref_op(int'(in_op), av, in_b);
        exp_q.push_back(e);
        model_acc = e;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_data, out_zero, out_ones, out_parity};
    end else stall_prev = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input logic acc, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_op = 3'(op); in_acc = acc; in_a = a; in_b = b;
    step();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 20, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_op = 0; in_acc = 0; in_a = 0; in_b = 0;
    acc_clr = 0; out_ready = 0;
    w_in_valid = 0; w_op = 0; w_a = 0; w_b = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_acc", acc_q, 0);
    chk("rst_out_data", out_data, 0);

    // Op sweep
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) issue(op, 1'b0, 4'b1100, 4'b1010);
    drain();

    // Accumulate chain
    issue(7, 1'b0, 4'b0000, 4'b1111);
    issue(0, 1'b1, 4'b0000, 4'b0110);
    issue(2, 1'b1, 4'b1111, 4'b0011);
    drain();
    chk("chain_acc", acc_q, 4'b0101);

    // Backpressure: two accepted, third refused
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = 3'(k + 1); in_acc = 0; in_a = 4'b1001; in_b = 4'(k + 3);
      #1;
      chk("bp_in_ready", in_ready, (k < 2) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("bp_out_valid", out_valid, 1);
    drain();

    // Clear collision
    issue(7, 1'b0, 4'b0000, 4'b1010);
    drain();
    chk("clr_pre_acc", acc_q, 4'b1010);
    issue(1, 1'b1, 4'b0000, 4'b0101);
    in_valid = 1'b0; acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    model_acc = '0;
    chk("clr_acc", acc_q, 0);
    chk("clr_out", out_data, 4'b1111);
    drain();

    // Reset mid-flight
    out_ready = 1'b0;
    issue(0, 1'b0, 4'b1111, 4'b1111);
    issue(1, 1'b0, 4'b1111, 4'b0001);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    model_acc = '0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_acc", acc_q, 0);
    chk("mid_rst_out_data", out_data, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_stale", out_valid, 0);
    end

    // Randomized traffic with drained clears
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 60; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 9) < 7);
        in_op     = 3'($urandom_range(0, 7));
        in_acc    = $urandom_range(0, 1) == 1;
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        step();
      end
      drain();
      chk("rand_acc", acc_q, model_acc);
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      model_acc = '0;
      chk("rand_clr", acc_q, 0);
    end

    // Width scaling: 16-bit NOR of zeros
    w_in_valid = 1'b1; w_op = 3'b100; w_a = 16'h0000; w_b = 16'h0000;
    #1;
    chk("w16_in_ready", w_in_ready, 1);
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!w_out_valid && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk("w16_timeout", n < 10, 1);
    end
    chk("w16_data", w_out_data, 16'hFFFF);
    chk("w16_ones", w_ones, 1);
    chk("w16_zero", w_zero, 0);
    chk("w16_parity", w_parity, 0);
    chk("w16_acc", w_acc_q, 16'hFFFF);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
